// File: rtl/map_pkg.sv
// Shared types and helpers for the parametrised line-frame mapper.
package map_pkg;

  typedef enum logic [1:0] {S_FAS, S_SEQ, S_PYLD, S_CRC} state_e;

  localparam int CRC_MAX_W = 64;
  localparam int DEF_ROWS  = 4;
  localparam int DEF_COLS  = 64;
  localparam int DEF_N     = DEF_ROWS * DEF_COLS;

  // Counter width that never collapses to zero bits.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One w-bit word folded into an MSB-first CRC (no reflection, no final xor).
  function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] crc,
                                                    input logic [CRC_MAX_W-1:0] data,
                                                    input logic [CRC_MAX_W-1:0] poly,
                                                    input int w);
    logic [CRC_MAX_W-1:0] r, rs, ds, mask;
    logic fb;
    r    = crc;
    mask = (w >= CRC_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < w) begin
        rs = r >> (w - 1);
        ds = data >> (w - 1 - i);
        fb = rs[0] ^ ds[0];
        r  = (r << 1) & mask;
        if (fb) r = r ^ (poly & mask);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_mapper_p_pos_cnt.sv
// Row / column / linear word position inside a ROWS x COLS frame.
module frame_pos_cnt
  import map_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = pos_w(ROWS),
  parameter int CW   = pos_w(COLS),
  parameter int LW   = pos_w(ROWS * COLS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [LW-1:0] o_lin
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lin_q, lin_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    lin_d = lin_q;
    if (i_adv) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      lin_d = (lin_q == LW'(ROWS * COLS - 1)) ? '0 : lin_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q <= '0;
      col_q <= '0;
      lin_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      lin_q <= lin_d;
    end
  end

  assign o_row = row_q;
  assign o_col = col_q;
  assign o_lin = lin_q;

endmodule

// File: rtl/frame_mapper_p.sv
// Line-frame builder: FAS words, ARQ sequence word, client payload, trailing CRC.
module frame_mapper_p
  import map_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ROWS     = 4,
  parameter int                COLS     = 64,
  parameter int                FAS_LEN  = 4,
  parameter logic [DATA_W-1:0] FAS_A    = 'hF6,
  parameter logic [DATA_W-1:0] FAS_B    = 'h28,
  parameter logic [DATA_W-1:0] CRC_POLY = 'h07,
  localparam int               RW       = pos_w(ROWS),
  localparam int               CW       = pos_w(COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_pyld_data,
  input  logic              i_pyld_data_valid,
  output logic              o_pyld_data_req,
  input  logic              i_line_fifo_ready,
  input  logic              i_retrans_req,
  input  logic              i_arq_en,
  input  logic              i_corrupt_en,
  output logic [DATA_W-1:0] o_frame_data,
  output logic              o_frame_data_valid,
  output logic              o_frame_data_fas,
  output logic [DATA_W-1:0] o_crc_val,
  output logic [DATA_W-1:0] o_seq_num,
  output logic [RW-1:0]     o_row_cnt,
  output logic [CW-1:0]     o_col_cnt
);

  localparam int N  = ROWS * COLS;
  localparam int LW = pos_w(N);

  if (N < FAS_LEN + 3) begin : g_geom_chk
    $error("frame_mapper_p: frame too short to hold FAS, seq and CRC words");
  end
  if (DATA_W > CRC_MAX_W) begin : g_width_chk
    $error("frame_mapper_p: DATA_W exceeds CRC helper width");
  end

  state_e            state_q, state_d;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [LW-1:0]     lin;
  logic              adv, is_fas;
  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] crc_q, crc_d, seq_q, seq_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] data_q, crcv_q;
  logic              vld_q, fas_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;

  // Payload words additionally need the client side; every other word only needs the line.
  assign adv             = i_line_fifo_ready & ((state_q != S_PYLD) | i_pyld_data_valid);
  assign o_pyld_data_req = (state_q == S_PYLD) & i_line_fifo_ready;

  frame_pos_cnt #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .LW(LW)) u_pos (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_adv (adv),
    .o_row (row),
    .o_col (col),
    .o_lin (lin)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FAS;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        S_FAS:   if (lin == LW'(FAS_LEN - 1)) state_d = S_SEQ;
        S_SEQ:   state_d = S_PYLD;
        S_PYLD:  if (lin == LW'(N - 2)) state_d = S_CRC;
        S_CRC:   state_d = S_FAS;
        default: state_d = S_FAS;
      endcase
    end
  end

  always_comb begin
    word_d = '0;
    is_fas = 1'b0;
    case (state_q)
      S_FAS: begin
        word_d = (lin < LW'(FAS_LEN / 2)) ? FAS_A : FAS_B;
        is_fas = 1'b1;
      end
      S_SEQ:   word_d = i_arq_en ? seq_q : '0;
      S_PYLD:  word_d = i_pyld_data;
      S_CRC:   word_d = crc_q ^ DATA_W'(i_corrupt_en);
      default: word_d = '0;
    endcase
  end

  // A retrans request seen any time up to and including the CRC advance holds the next seq.
  always_comb begin
    crc_d  = crc_q;
    seq_d  = seq_q;
    pend_d = pend_q;
    if (adv && (state_q == S_SEQ || state_q == S_PYLD))
      crc_d = DATA_W'(crc_step(64'(crc_q), 64'(word_d), 64'(CRC_POLY), DATA_W));
    else if (adv && state_q == S_CRC)
      crc_d = '0;
    if (adv && state_q == S_CRC) begin
      pend_d = 1'b0;
      if (i_arq_en && !pend_q && !i_retrans_req) seq_d = seq_q + 1'b1;
    end else if (i_retrans_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_q  <= '0;
      seq_q  <= '0;
      pend_q <= 1'b0;
      data_q <= '0;
      vld_q  <= 1'b0;
      fas_q  <= 1'b0;
      crcv_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      crc_q  <= crc_d;
      seq_q  <= seq_d;
      pend_q <= pend_d;
      vld_q  <= adv;
      fas_q  <= adv & is_fas;
      if (adv) begin
        data_q <= word_d;
        row_q  <= row;
        col_q  <= col;
      end
      if (adv && state_q == S_CRC) crcv_q <= crc_q;
    end
  end

  assign o_frame_data       = data_q;
  assign o_frame_data_valid = vld_q;
  assign o_frame_data_fas   = fas_q;
  assign o_crc_val          = crcv_q;
  assign o_seq_num          = seq_q;
  assign o_row_cnt          = row_q;
  assign o_col_cnt          = col_q;

endmodule

// File: tb/tb_frame_mapper_p.sv
// Directed + randomized bench for frame_mapper_p against a frame-level reference model.
module tb_frame_mapper_p;
  localparam int DW = 8, ROWS = 1, COLS = 8, FL = 2;
  localparam int N = ROWS * COLS, NP = N - FL - 2;

  logic          clk = 1'b0;
  logic          rst, valid, ready, retrans, arq, corrupt;
  logic [DW-1:0] data;
  logic          req, o_valid, o_fas;
  logic [DW-1:0] o_data, o_crc, o_seq;
  logic [0:0]    o_row;
  logic [2:0]    o_col;

  frame_mapper_p #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .FAS_LEN(FL),
                   .FAS_A(8'hF6), .FAS_B(8'h28), .CRC_POLY(8'h07)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pyld_data        (data),
    .i_pyld_data_valid  (valid),
    .o_pyld_data_req    (req),
    .i_line_fifo_ready  (ready),
    .i_retrans_req      (retrans),
    .i_arq_en           (arq),
    .i_corrupt_en       (corrupt),
    .o_frame_data       (o_data),
    .o_frame_data_valid (o_valid),
    .o_frame_data_fas   (o_fas),
    .o_crc_val          (o_crc),
    .o_seq_num          (o_seq),
    .o_row_cnt          (o_row),
    .o_col_cnt          (o_col)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fas;
    logic [2:0] col;
  } exp_t;

  logic [7:0] pyq[$];
  exp_t       expq[$];
  exp_t       ce;
  int         n_tests = 0, n_fail = 0;
  int         m_seq = 0;
  logic [7:0] m_crc = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of message * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    logic [8:0] r;
    r = '0;
    foreach (msg[i])
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], msg[i][b]};
        if (r[8]) r = r ^ 9'h107;
      end
    for (int b = 0; b < 8; b++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic add_frame(input bit a, input bit cor, input bit hold, input bit rnd);
    logic [7:0] msg[$];
    logic [7:0] sw, c, b;
    exp_t e;
    sw = a ? 8'(m_seq) : 8'h00;
    msg.push_back(sw);
    for (int j = 0; j < NP; j++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : 8'(j + 1);
      msg.push_back(b);
      pyq.push_back(b);
    end
    c = crc_ref(msg);
    for (int p = 0; p < N; p++) begin
      if (p < FL)         e.d = (p < FL / 2) ? 8'hF6 : 8'h28;
      else if (p < N - 1) e.d = msg[p - FL];
      else                e.d = c ^ 8'(cor);
      e.fas = (p < FL);
      e.col = 3'(p);
      expq.push_back(e);
    end
    m_crc = c;
    if (a && !hold) m_seq = (m_seq + 1) % 256;
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (expq.size() == 0) chk("extra_word", 1, 0);
      else begin
        ce = expq.pop_front();
        chk("word", o_data, ce.d);
        chk("fas", o_fas, ce.fas);
        chk("col", o_col, ce.col);
        chk("row", o_row, 0);
      end
    end
  end

  // mode 0: always ready/valid; 1: ready toggles, valid gap; 2: random.
  task automatic run(input int mode, input int budget, input int r1, input int r2, input bit hdr);
    int i;
    bit rdy, vld, take;
    i = 0;
    forever begin
      @(negedge clk); #1;
      if (expq.size() == 0 || i >= budget) break;
      case (mode)
        0:       begin rdy = 1'b1; vld = 1'b1; end
        1:       begin rdy = (i % 2 == 0); vld = !(i >= 6 && i <= 8); end
        default: begin rdy = ($urandom_range(0, 3) != 0); vld = ($urandom_range(0, 3) != 0); end
      endcase
      ready   = rdy;
      retrans = (i == r1 || i == r2);
      valid   = vld && (pyq.size() > 0);
      data    = (pyq.size() > 0) ? pyq[0] : 8'h00;
      #1;
      if (!rdy) chk("req_when_not_ready", req, 0);
      if (hdr && i < FL + 1) chk("req_in_header", req, 0);
      take = valid && req;
      @(posedge clk);
      if (take) void'(pyq.pop_front());
      i++;
    end
    ready = 0; valid = 0; retrans = 0;
    chk("frames_done", expq.size(), 0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk); #1;
    rst = 1; ready = 1; valid = 1; data = 8'hA5; retrans = 1;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_fas", o_fas, 0);
      chk("rst_crc", o_crc, 0);
      chk("rst_seq", o_seq, 0);
      chk("rst_row", o_row, 0);
      chk("rst_col", o_col, 0);
      chk("rst_req", req, 0);
    end
    @(negedge clk); #1;
    rst = 0; ready = 0; valid = 0; retrans = 0;
    pyq.delete(); expq.delete();
    m_seq = 0; m_crc = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; valid = 0; ready = 0; retrans = 0; arq = 1; corrupt = 0; data = '0;

    // Basic frame
    do_reset(1);
    add_frame(1, 0, 0, 0);
    run(0, 50, -1, -1, 0);
    chk("t1_crc_const", o_crc, 8'hE3);
    chk("t1_crc_model", o_crc, m_crc);
    chk("t1_seq", o_seq, m_seq);

    // Corrupted CRC word, clean CRC value
    do_reset(0);
    corrupt = 1;
    add_frame(1, 1, 0, 0);
    run(0, 50, -1, -1, 0);
    chk("t2_crc_val", o_crc, 8'hE3);
    corrupt = 0;

    // Back-pressure
    do_reset(0);
    add_frame(1, 0, 0, 0);
    run(1, 100, -1, -1, 0);
    chk("t3_crc_val", o_crc, m_crc);
    chk("t3_seq", o_seq, m_seq);

    // Retransmit: mid-frame pulse in frame 0, pulse on CRC advance of frame 2
    do_reset(0);
    add_frame(1, 0, 1, 1);
    add_frame(1, 0, 0, 1);
    add_frame(1, 0, 1, 1);
    add_frame(1, 0, 0, 1);
    add_frame(1, 0, 0, 1);
    run(0, 100, 3, 2 * N + N - 1, 0);
    chk("t4_seq", o_seq, m_seq);
    chk("t4_crc_val", o_crc, m_crc);

    // ARQ off, random back-pressure
    arq = 0;
    for (int f = 0; f < 3; f++) add_frame(0, 0, 0, 1);
    run(2, 400, -1, -1, 0);
    chk("t5_seq_hold", o_seq, m_seq);
    chk("t5_crc_val", o_crc, m_crc);
    arq = 1;

    // Reset mid-payload, then restart from FAS with seq 0
    do_reset(0);
    add_frame(1, 0, 0, 1);
    while (expq.size() > FL + 3) void'(expq.pop_back());
    run(0, 50, -1, -1, 0);
    rst = 1; ready = 1; valid = 1; data = 8'h5A;
    @(posedge clk); #1;
    chk("t6_valid_after_rst", o_valid, 0);
    chk("t6_seq_after_rst", o_seq, 0);
    chk("t6_col_after_rst", o_col, 0);
    @(negedge clk); #1;
    rst = 0; ready = 0; valid = 0;
    pyq.delete(); expq.delete(); m_seq = 0; m_crc = 8'h00;
    add_frame(1, 0, 0, 1);
    run(0, 50, -1, -1, 1);
    chk("t6_seq", o_seq, m_seq);

    // Randomized back-pressure with ARQ on
    for (int f = 0; f < 4; f++) add_frame(1, 0, 0, 1);
    run(2, 500, -1, -1, 0);
    chk("t7_seq", o_seq, m_seq);
    chk("t7_crc_val", o_crc, m_crc);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
